// File: rtl/hi_pkg.sv
// Shared constants for the HF reader correlator and its on-chip SSP consumers.
// Both sides use these to agree on word width, I/Q byte packing and minor modes.
package hi_pkg;

    localparam int unsigned SSP_WORD_W = 16;

    // I (or amplitude) byte is sent first, so it lands in the upper half.
    localparam int unsigned I_MSB = 15;
    localparam int unsigned I_LSB = 8;
    localparam int unsigned Q_MSB = 7;
    localparam int unsigned Q_LSB = 0;

    localparam logic [2:0] MINOR_MODE_RX_XCORR     = 3'd0;
    localparam logic [2:0] MINOR_MODE_RX_AMPLITUDE = 3'd1;
    localparam logic [2:0] MINOR_MODE_RX_IQ        = 3'd2;
    localparam logic [2:0] MINOR_MODE_TX           = 3'd3;

    typedef struct packed {
        logic [7:0] i_byte;
        logic [7:0] q_byte;
    } ssp_word_t;

endpackage

// File: rtl/ssp_word_fifo.sv
// Synchronous first-word-fall-through FIFO with registered pointers and count.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module ssp_word_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (count == '0);
        full    = (count == (AW + 1)'(DEPTH));
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        rdata   = mem[rptr];
        level   = count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW + 1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/hi_ssp_capture.sv
// Deserialises the correlator's SSP stream into 16-bit {I, Q} words and buffers them
// in an FWFT FIFO, tracking dropped words and mid-word frame restarts.
module hi_ssp_capture
    import hi_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned ERR_W = 8
) (
    input  logic                    ck_1356meg,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    ssp_clk,
    input  logic                    ssp_frame,
    input  logic                    ssp_din,
    input  logic                    rd_en,
    output logic [SSP_WORD_W-1:0]   rd_data,
    output logic                    rd_valid,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    input  logic                    clr_ovf,
    output logic [ERR_W-1:0]        frame_err_cnt
);

    logic                  s_clk;
    logic                  s_clk_d;
    logic                  s_frame;
    logic                  s_din;
    logic                  sclk_fall;
    logic [3:0]            bit_cnt;
    logic [SSP_WORD_W-1:0] shreg;
    logic                  push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;

    always_comb begin
        sclk_fall = s_clk_d & ~s_clk;
        rd_valid  = ~fifo_empty;
        pop       = rd_en & rd_valid;
    end

    always_ff @(posedge ck_1356meg or negedge rst_n) begin
        if (!rst_n) begin
            s_clk   <= 1'b0;
            s_clk_d <= 1'b0;
            s_frame <= 1'b0;
            s_din   <= 1'b0;
        end else begin
            s_clk   <= ssp_clk;
            s_clk_d <= s_clk;
            s_frame <= ssp_frame;
            s_din   <= ssp_din;
        end
    end

    // shreg holds the finished word during the push cycle; the next sample is
    // at least four cycles away, so it is safe to feed the FIFO straight from it.
    always_ff @(posedge ck_1356meg or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt       <= '0;
            shreg         <= '0;
            push          <= 1'b0;
            frame_err_cnt <= '0;
        end else begin
            push <= 1'b0;
            if (!enable) begin
                bit_cnt <= '0;
            end else if (sclk_fall) begin
                if (s_frame) begin
                    shreg   <= {{(SSP_WORD_W - 1){1'b0}}, s_din};
                    bit_cnt <= 4'd1;
                    if (bit_cnt != 4'd0 && frame_err_cnt != '1) begin
                        frame_err_cnt <= frame_err_cnt + ERR_W'(1);
                    end
                end else if (bit_cnt == 4'd15) begin
                    shreg   <= {shreg[SSP_WORD_W-2:0], s_din};
                    push    <= 1'b1;
                    bit_cnt <= 4'd0;
                end else if (bit_cnt != 4'd0) begin
                    shreg   <= {shreg[SSP_WORD_W-2:0], s_din};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge ck_1356meg or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    ssp_word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SSP_WORD_W)
    ) u_fifo (
        .clk   (ck_1356meg),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (shreg),
        .rdata (rd_data),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
